// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the multiplier controller state type.
package alu_pkg;
   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_e;
endpackage

// File: rtl/alu.sv
// Existing 32-bit ALU: AND/OR/ADD/SUB/SLT with unsigned carry, signed overflow and zero flags.
module alu
   import alu_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUop,
   output logic        Overflow,
   output logic        CarryOut,
   output logic        Zero,
   output logic [31:0] Result
);
   logic        sub;
   logic [31:0] b_op;
   logic [32:0] sum;

   always_comb begin
      sub      = (ALUop == ALU_SUB) || (ALUop == ALU_SLT);
      b_op     = sub ? ~B : B;
      sum      = {1'b0, A} + {1'b0, b_op} + {32'd0, sub};
      CarryOut = sum[32];
      Overflow = (A[31] == b_op[31]) && (sum[31] != A[31]);
      case (ALUop)
         ALU_AND: Result = A & B;
         ALU_OR:  Result = A | B;
         ALU_ADD: Result = sum[31:0];
         ALU_SUB: Result = sum[31:0];
         ALU_SLT: Result = {31'd0, sum[31] ^ Overflow};
         default: Result = 32'd0;
      endcase
      Zero = (Result == 32'd0);
   end
endmodule

// File: rtl/alu_mult_ctrl.sv
// Shift-add unsigned multiplier controller using the shared ALU as its adder.
// Optional MULT_EARLY_TERM_EN: zero operands skip straight to DONE.
module alu_mult_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH);

   mult_state_e      state, next_state;
   logic [WIDTH-1:0] mcand, hi, lo;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_ovf_unused, alu_zero_unused;
   logic             accept, last_iter, early_zero;

`ifdef MULT_EARLY_TERM_EN
   assign early_zero = (in_a == '0) || (in_b == '0);
`else
   assign early_zero = 1'b0;
`endif

   alu u_alu (hi, mcand, ALU_ADD, alu_ovf_unused, alu_carry, alu_zero_unused, alu_result);

   assign accept    = (state == IDLE) && in_valid;
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = early_zero ? DONE : RUN;
         RUN:     if (last_iter) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // {hi,lo} shifts right each iteration; the adder carry becomes hi's new MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
      end else if (accept) begin
         mcand <= in_a;
         hi    <= '0;
         lo    <= early_zero ? '0 : in_b;
         cnt   <= '0;
      end else if (state == RUN) begin
         if (lo[0]) begin
            hi <= {alu_carry, alu_result[WIDTH-1:1]};
            lo <= {alu_result[0], lo[WIDTH-1:1]};
         end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
         end
         cnt <= cnt + 1'b1;
      end
   end

   assign in_ready  = (state == IDLE) & ~rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_hi    = (state == DONE) ? hi : '0;
   assign out_lo    = (state == DONE) ? lo : '0;
endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Bench for alu_mult_ctrl: directed products, latency, back-pressure and mid-run reset.
module tb_alu_mult_ctrl;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a, in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_hi, out_lo;
   logic         busy;

   logic [2*W-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   alu_mult_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hi(out_hi), .out_lo(out_lo), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every delivered product is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_product: got 0x%0h expected none", {out_hi, out_lo});
         end else begin
            check("product", {out_hi, out_lo}, exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_prod, input int exp_lat, input int stall);
      int lat;
      exp_q.push_back(exp_prod);
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = (stall == 0);
      @(negedge clk);
      check("accept_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      lat = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
         if (lat > 100) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no out_valid expected within 100 cycles");
            break;
         end
      end
      check("latency", 64'(lat), 64'(exp_lat));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_hold", {out_hi, out_lo}, exp_prod);
         check("stall_in_ready", {62'd0, in_ready, out_valid}, 64'd1);
      end
      if (stall > 0) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check("post_delivery", {61'd0, in_ready, out_valid, busy}, 64'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected within 200000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", {out_valid, busy, in_ready, out_hi, out_lo}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {62'd0, in_ready, busy}, 64'd2);

      run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 32, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 0);
      run_op(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 32, 0);
      run_op(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 32, 0);
      run_op(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 32, 10);

      // Mid-run reset: nothing is queued, so any delivery would be flagged.
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 32'h0000_FFFF; in_b = 32'h0000_FFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("reset_midrun", {62'd0, out_valid, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_midrun_reset", {63'd0, in_ready}, 64'd1);
      run_op(32'd7, 32'd6, 64'd42, 32, 0);

`ifdef MULT_EARLY_TERM_EN
      run_op(32'd0, 32'h0000_1234, 64'd0, 0, 0);
`else
      run_op(32'd0, 32'h0000_1234, 64'd0, 32, 0);
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
